// File: rtl/stopwatch_bcd.sv
// BCD stopwatch MM:SS.cc driven by the 1/100 s tick; run/pause/clear by command pulses.
// Optional lap-hold display freeze is compiled in when LAP_HOLD_EN is defined.
module stopwatch_bcd #(
  parameter int MIN_MAX = 59
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        TICK,
  input  logic        START_STOP,
  input  logic        CLEAR,
  input  logic        LAP,
  output logic [23:0] DIGITS,
  output logic        RUNNING,
  output logic        ROLLOVER,
  output logic        LAP_ACTIVE
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [3:0] MM_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MM_O = 4'(MIN_MAX % 10);

  state_t      state;
  logic [23:0] count_p0;

  // Advance the packed BCD count by one hundredth; MSB of the result flags the wrap.
  function automatic logic [24:0] bcd_advance(input logic [23:0] c);
    logic [3:0] mt, mo, st, so, ct, co;
    logic       wrap;
    {mt, mo, st, so, ct, co} = c;
    wrap = 1'b0;
    if (co != 4'd9) begin
      co = co + 4'd1;
    end else begin
      co = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (so != 4'd9) begin
          so = so + 4'd1;
        end else begin
          so = 4'd0;
          if (st != 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if (mt == MM_T && mo == MM_O) begin
              mt   = 4'd0;
              mo   = 4'd0;
              wrap = 1'b1;
            end else if (mo != 4'd9) begin
              mo = mo + 4'd1;
            end else begin
              mo = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, mt, mo, st, so, ct, co};
  endfunction

  function automatic state_t next_state(input state_t s, input logic ss);
    state_t n;
    n = s;
    if (ss) begin
      case (s)
        IDLE:    n = RUN;
        RUN:     n = PAUSE;
        PAUSE:   n = RUN;
        default: n = IDLE;
      endcase
    end
    return n;
  endfunction

`ifdef LAP_HOLD_EN
  logic        lap_p0;
  logic [23:0] held_p0;
`else
  logic        unused_lap;
  assign unused_lap = LAP;
`endif

  // Stage p0: state, count, rollover and lap hold all update on the same edge
  always_ff @(posedge CLOCK) begin
    if (RESET || CLEAR) begin
      state    <= IDLE;
      RUNNING  <= 1'b0;
      count_p0 <= 24'h000000;
      ROLLOVER <= 1'b0;
`ifdef LAP_HOLD_EN
      lap_p0   <= 1'b0;
      held_p0  <= 24'h000000;
`endif
    end else begin
      ROLLOVER <= 1'b0;
      if (state == RUN && TICK) begin
        {ROLLOVER, count_p0} <= bcd_advance(count_p0);
      end
      state   <= next_state(state, START_STOP);
      RUNNING <= (next_state(state, START_STOP) == RUN);
`ifdef LAP_HOLD_EN
      // Freeze captures the count as displayed before any tick on this edge.
      if (LAP && state != IDLE) begin
        lap_p0 <= !lap_p0;
        if (!lap_p0) begin
          held_p0 <= count_p0;
        end
      end
`endif
    end
  end

`ifdef LAP_HOLD_EN
  assign DIGITS     = lap_p0 ? held_p0 : count_p0;
  assign LAP_ACTIVE = lap_p0;
`else
  assign DIGITS     = count_p0;
  assign LAP_ACTIVE = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Testbench for stopwatch_bcd: integer-hundredths reference model, per-cycle compare,
// directed literal scenarios, then randomized command/tick traffic.
module tb_stopwatch_bcd;
  localparam int MIN_MAX = 1;
  localparam int WRAP_CS = (MIN_MAX + 1) * 6000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        TICK = 1'b0;
  logic        START_STOP = 1'b0;
  logic        CLEAR = 1'b0;
  logic        LAP = 1'b0;
  logic [23:0] DIGITS;
  logic        RUNNING;
  logic        ROLLOVER;
  logic        LAP_ACTIVE;

  stopwatch_bcd #(.MIN_MAX(MIN_MAX)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .START_STOP(START_STOP),
    .CLEAR(CLEAR), .LAP(LAP), .DIGITS(DIGITS), .RUNNING(RUNNING),
    .ROLLOVER(ROLLOVER), .LAP_ACTIVE(LAP_ACTIVE)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed time as plain hundredths, mode 0=idle 1=run 2=pause.
  int   m_total = 0;
  int   m_held = 0;
  int   m_mode = 0;
  logic m_roll = 1'b0;
  logic m_lap = 1'b0;
  logic m_valid = 1'b0;

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] exp_digits();
    return to_bcd(m_lap ? m_held : m_total);
  endfunction

  task automatic model_update(input logic t, input logic ss, input logic c,
                              input logic l, input logic r);
    int old_total;
    if (r || c) begin
      m_total = 0; m_held = 0; m_mode = 0; m_roll = 1'b0; m_lap = 1'b0;
    end else begin
      old_total = m_total;
      m_roll = 1'b0;
      if (m_mode == 1 && t) begin
        m_total = m_total + 1;
        if (m_total == WRAP_CS) begin
          m_total = 0;
          m_roll  = 1'b1;
        end
      end
`ifdef LAP_HOLD_EN
      if (l && m_mode != 0) begin
        if (!m_lap) m_held = old_total;
        m_lap = !m_lap;
      end
`endif
      if (ss) m_mode = (m_mode == 1) ? 2 : 1;
    end
    m_valid = 1'b1;
  endtask

  task automatic step(input logic t, input logic ss, input logic c,
                      input logic l, input logic r);
    TICK = t; START_STOP = ss; CLEAR = c; LAP = l; RESET = r;
    @(posedge CLOCK);
    model_update(t, ss, c, l, r);
    #1;
    TICK = 1'b0; START_STOP = 1'b0; CLEAR = 1'b0; LAP = 1'b0; RESET = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  int printed = 0;
  always @(negedge CLOCK) begin
    if (m_valid) begin
      checks += 4;
      if (DIGITS !== exp_digits() || RUNNING !== (m_mode == 1) ||
          ROLLOVER !== m_roll || LAP_ACTIVE !== m_lap) begin
        if (DIGITS !== exp_digits()) errors++;
        if (RUNNING !== (m_mode == 1)) errors++;
        if (ROLLOVER !== m_roll) errors++;
        if (LAP_ACTIVE !== m_lap) errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL cycle: got digits=%h run=%b roll=%b lap=%b, expected digits=%h run=%b roll=%b lap=%b at %0t",
                   DIGITS, RUNNING, ROLLOVER, LAP_ACTIVE, exp_digits(), m_mode == 1, m_roll, m_lap, $time);
        end
      end
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_digits", DIGITS, 24'h000000);
    chk("reset_running", {23'd0, RUNNING}, 24'd0);

    // Start then 100 ticks -> 00:01.00
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(100);
    chk("t1_digits", DIGITS, 24'h000100);
    chk("t1_running", {23'd0, RUNNING}, 24'd1);
    chk("t1_rollover", {23'd0, ROLLOVER}, 24'd0);

    // Wrap at MIN_MAX=1: 01:59.99 -> 00:00.00 with one-cycle ROLLOVER
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(11999);
    chk("t2_full", DIGITS, 24'h015999);
    ticks(1);
    chk("t2_wrap", DIGITS, 24'h000000);
    chk("t2_roll_hi", {23'd0, ROLLOVER}, 24'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_roll_lo", {23'd0, ROLLOVER}, 24'd0);
    ticks(3);
    chk("t2_after_wrap", DIGITS, 24'h000003);

    // START_STOP with TICK in RUN counts the tick then pauses
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_digits", DIGITS, 24'h000006);
    chk("t3_running", {23'd0, RUNNING}, 24'd0);
    ticks(20);
    chk("t3_held", DIGITS, 24'h000006);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_resume_nocount", DIGITS, 24'h000006);

    // CLEAR beats START_STOP while paused
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(317);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_paused", DIGITS, 24'h000317);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_digits", DIGITS, 24'h000000);
    chk("t4_running", {23'd0, RUNNING}, 24'd0);
    ticks(4);
    chk("t4_idle_stays", DIGITS, 24'h000000);

`ifdef LAP_HOLD_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(123);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(50);
    chk("t5_frozen", DIGITS, 24'h000123);
    chk("t5_lap_on", {23'd0, LAP_ACTIVE}, 24'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_release", DIGITS, 24'h000173);
    chk("t5_lap_off", {23'd0, LAP_ACTIVE}, 24'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("lap_ignored", DIGITS, 24'h000009);
    chk("lap_inactive", {23'd0, LAP_ACTIVE}, 24'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // RESET overrides TICK in RUN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1234);
    chk("t6_before", DIGITS, 24'h001234);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_digits", DIGITS, 24'h000000);
    chk("t6_running", {23'd0, RUNNING}, 24'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 30000; i++) begin
      logic t, ss, c, l, r;
      t  = ($urandom_range(0, 99) < 80);
      ss = ($urandom_range(0, 999) < 8);
      c  = ($urandom_range(0, 9999) < 3);
      l  = ($urandom_range(0, 999) < 10);
      r  = ($urandom_range(0, 9999) < 2);
      step(t, ss, c, l, r);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
